mips_mc_ctrl: RTL and testbench
===============================

MIPS_MC_CTRL -- requirements
Module: mips_mc_ctrl

Interface
REQ-001 Parameter: MEM_TIMEOUT, default 16, max wait cycles for mem_ready in a memory state before abort.
REQ-002 Port: clk  in  1  sole clock, all state on rising edge.
REQ-003 Port: rst  in  1  asynchronous, active-low reset.
REQ-004 Port: opc  in  6  instruction opcode, valid from DECODE onward.
REQ-005 Port: func  in  6  R-type function field.
REQ-006 Port: zero  in  1  ALU zero flag.
REQ-007 Port: mem_ready  in  1  data memory access complete.
REQ-008 Port: pc_write, ir_write  out  1 each  PC update strobe, instruction register load.
REQ-009 Port: ALUOpration  out  3  000 and, 001 or, 010 add, 011 sub, 100 slt.
REQ-010 Port: MemRead, MemWrite, RegWrite, PCSrc, RegDst, ALUSrc, MemToReg, PCToReg, LastReg, AdrToPC, RegToPC  out  1 each  datapath controls, MIPS_DP meaning.
REQ-011 Port: instr_done  out  1  one-cycle pulse on last cycle of each instruction.
REQ-012 Port: illegal, mem_err  out  1 each  sticky error flags.
REQ-013 Port: instr_count  out  32  retired-instruction counter.

Function
REQ-014 Moore FSM, outputs registered-state decoded; every control output is 0 unless listed for the current state.
REQ-015 States: FETCH, DECODE, R_EXE, R_WB, I_EXE, I_WB, MEM_ADR, LW_RD, LW_WB, SW_WR, BEQ, JUMP, JAL, JR, ILL.
REQ-016 FETCH: pc_write=1, ir_write=1 (PC+4 path); -> DECODE.
REQ-017 DECODE: no strobes; next state by opc/func: 000000 with func 100000/100010/100100/100101/101010 -> R_EXE, func 001000 -> JR; 001000 addi, 001010 slti -> I_EXE; 100011 lw, 101011 sw -> MEM_ADR; 000100 -> BEQ; 000010 -> JUMP; 000011 -> JAL; anything else -> ILL.
REQ-018 R_EXE: ALUOpration by func (add 010, sub 011, and 000, or 001, slt 100) -> R_WB; R_WB: same ALUOpration, RegDst=1, RegWrite=1, instr_done=1 -> FETCH.
REQ-019 I_EXE: ALUSrc=1, ALUOpration 010 (addi) or 100 (slti) -> I_WB; I_WB: same plus RegWrite=1, instr_done=1 -> FETCH.
REQ-020 MEM_ADR: ALUSrc=1, ALUOpration=010; -> LW_RD (lw) or SW_WR (sw).
REQ-021 LW_RD: MEM_ADR controls plus MemRead=1; stays until mem_ready=1, then -> LW_WB; LW_WB: MemRead=1, MemToReg=1, RegWrite=1, ALUSrc=1, ALUOpration=010, instr_done=1 -> FETCH.
REQ-022 SW_WR: MEM_ADR controls plus MemWrite=1; stays until mem_ready=1; in the mem_ready cycle instr_done=1 -> FETCH.
REQ-023 Wait counter clears on entry to LW_RD/SW_WR, increments each cycle mem_ready=0; when it reaches MEM_TIMEOUT with mem_ready=0: mem_err set, RegWrite/MemWrite deasserted that cycle, instr_done=1, -> FETCH; mem_ready=1 in the same cycle wins (normal completion).
REQ-024 BEQ: ALUOpration=011, PCSrc=1, pc_write=zero, instr_done=1 -> FETCH.
REQ-025 JUMP: AdrToPC=1, pc_write=1, instr_done=1; JAL: JUMP controls plus PCToReg=1, LastReg=1, RegWrite=1; JR: RegToPC=1, pc_write=1, instr_done=1; all -> FETCH.
REQ-026 ILL: illegal set, no strobes, instr_done=0 -> FETCH (instruction skipped, not counted).
REQ-027 Latency (zero wait): R/I/sw 4 cycles, lw 5, beq/j/jal/jr 3; each wait cycle adds 1.
REQ-028 instr_count increments by 1 per instr_done pulse, wraps 0xFFFFFFFF -> 0.
REQ-029 illegal and mem_err stay set until reset.

Reset
REQ-030 rst=0 immediately forces FETCH state, wait counter 0, instr_count 0, illegal=0, mem_err=0, independent of clk, including mid-instruction or mid-wait.
REQ-031 While rst=0, every control output except FETCH's pc_write/ir_write is 0; pc_write and ir_write also forced 0 during reset.
REQ-032 First rising clk edge after rst deasserts executes FETCH.

Verification
REQ-033 add (opc 000000, func 100000) -> FETCH, DECODE, R_EXE, R_WB; RegWrite=1 and RegDst=1 only in R_WB; instr_count 0->1.
REQ-034 lw with mem_ready low 3 cycles -> LW_RD held 4 cycles, LW_WB follows, total 8 cycles, MemRead high throughout LW_RD/LW_WB.
REQ-035 beq with zero=1 then zero=0 -> pc_write 1 then 0 in BEQ; both 3 cycles, both counted.
REQ-036 sw with mem_ready stuck 0, MEM_TIMEOUT=16 -> mem_err=1 after 16 wait cycles, return to FETCH, instr_count incremented.
REQ-037 opc 111111 -> illegal=1, back to FETCH after 2 cycles, instr_count unchanged; jal next -> LastReg=PCToReg=RegWrite=pc_write=1 in JAL.
REQ-038 rst asserted during LW_RD wait -> all outputs 0, instr_count 0, FETCH on first edge after release.

Source files
------------

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control unit: Moore FSM that sequences the shared
// datapath (FETCH/DECODE/execute/writeback), waits on data memory with a
// bounded timeout, and keeps sticky error flags plus a retired-instruction
// counter.
module mips_mc_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opc,
  input  logic [5:0]  func,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        ir_write,
  output logic [2:0]  ALUOpration,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic        PCSrc,
  output logic        RegDst,
  output logic        ALUSrc,
  output logic        MemToReg,
  output logic        PCToReg,
  output logic        LastReg,
  output logic        AdrToPC,
  output logic        RegToPC,
  output logic        instr_done,
  output logic        illegal,
  output logic        mem_err,
  output logic [31:0] instr_count
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  // R-type function codes
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_JR  = 6'b001000;

  // ALU operation encodings
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_R_EXE, S_R_WB, S_I_EXE, S_I_WB, S_MEM_ADR,
    S_LW_RD, S_LW_WB, S_SW_WR, S_BEQ, S_JUMP, S_JAL, S_JR, S_ILL
  } state_e;

  // All datapath controls bundled so reset gating is a single assignment.
  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic [2:0] alu_op;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       pc_src;
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       pc_to_reg;
    logic       last_reg;
    logic       adr_to_pc;
    logic       reg_to_pc;
    logic       instr_done;
  } ctrl_t;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [31:0]       count_q;
  logic              illegal_q;
  logic              mem_err_q;
  logic              in_mem_wait;
  logic              timeout;
  ctrl_t             ctrl;
  ctrl_t             ctrl_out;

  function automatic logic r_func_legal(input logic [5:0] f);
    return (f == F_ADD) || (f == F_SUB) || (f == F_AND) ||
           (f == F_OR)  || (f == F_SLT);
  endfunction

  function automatic logic [2:0] r_alu_op(input logic [5:0] f);
    logic [2:0] op;
    op = ALU_AND;
    case (f)
      F_ADD:   op = ALU_ADD;
      F_SUB:   op = ALU_SUB;
      F_AND:   op = ALU_AND;
      F_OR:    op = ALU_OR;
      F_SLT:   op = ALU_SLT;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // The wait counter holds the number of mem_ready=0 cycles already spent in
  // the memory state; abort happens in the MEM_TIMEOUT-th such cycle, and a
  // mem_ready in that same cycle still completes normally.
  assign in_mem_wait = (state_q == S_LW_RD) || (state_q == S_SW_WR);
  assign timeout     = in_mem_wait && !mem_ready &&
                       (wait_q == WAIT_W'(MEM_TIMEOUT - 1));

  // Next-state selection from current state, decoded opcode and handshakes.
  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so no
    // path through the case can leave it unassigned and infer a latch.
    state_d = state_q;
    unique case (state_q)
      S_FETCH:   state_d = S_DECODE;
      S_DECODE: begin
        case (opc)
          OP_RTYPE: begin
            if (func == F_JR)            state_d = S_JR;
            else if (r_func_legal(func)) state_d = S_R_EXE;
            else                         state_d = S_ILL;
          end
          OP_ADDI, OP_SLTI: state_d = S_I_EXE;
          OP_LW, OP_SW:     state_d = S_MEM_ADR;
          OP_BEQ:           state_d = S_BEQ;
          OP_J:             state_d = S_JUMP;
          OP_JAL:           state_d = S_JAL;
          default:          state_d = S_ILL;
        endcase
      end
      S_R_EXE:   state_d = S_R_WB;
      S_I_EXE:   state_d = S_I_WB;
      S_MEM_ADR: state_d = (opc == OP_SW) ? S_SW_WR : S_LW_RD;
      S_LW_RD: begin
        if (mem_ready)    state_d = S_LW_WB;
        else if (timeout) state_d = S_FETCH;
      end
      S_SW_WR: begin
        if (mem_ready || timeout) state_d = S_FETCH;
      end
      default:   state_d = S_FETCH;
    endcase
  end

  // Wait counter: cleared while computing the address, counts stalled cycles.
  always_comb begin
    wait_d = wait_q;
    if (state_q == S_MEM_ADR) begin
      wait_d = '0;
    end else if (in_mem_wait && !mem_ready) begin
      wait_d = wait_q + WAIT_W'(1);
    end
  end

  // Moore control decode: everything 0 unless the current state asserts it.
  always_comb begin
    ctrl = '0;
    unique case (state_q)
      S_FETCH: begin
        ctrl.pc_write = 1'b1;
        ctrl.ir_write = 1'b1;
      end
      S_R_EXE: ctrl.alu_op = r_alu_op(func);
      S_R_WB: begin
        ctrl.alu_op     = r_alu_op(func);
        ctrl.reg_dst    = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_I_EXE: begin
        ctrl.alu_src = 1'b1;
        ctrl.alu_op  = (opc == OP_SLTI) ? ALU_SLT : ALU_ADD;
      end
      S_I_WB: begin
        ctrl.alu_src    = 1'b1;
        ctrl.alu_op     = (opc == OP_SLTI) ? ALU_SLT : ALU_ADD;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEM_ADR: begin
        ctrl.alu_src = 1'b1;
        ctrl.alu_op  = ALU_ADD;
      end
      S_LW_RD: begin
        ctrl.alu_src    = 1'b1;
        ctrl.alu_op     = ALU_ADD;
        ctrl.mem_read   = 1'b1;
        ctrl.instr_done = timeout;
      end
      S_LW_WB: begin
        ctrl.alu_src    = 1'b1;
        ctrl.alu_op     = ALU_ADD;
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_SW_WR: begin
        ctrl.alu_src    = 1'b1;
        ctrl.alu_op     = ALU_ADD;
        ctrl.mem_write  = !timeout;
        ctrl.instr_done = mem_ready || timeout;
      end
      S_BEQ: begin
        ctrl.alu_op     = ALU_SUB;
        ctrl.pc_src     = 1'b1;
        ctrl.pc_write   = zero;
        ctrl.instr_done = 1'b1;
      end
      S_JUMP: begin
        ctrl.adr_to_pc  = 1'b1;
        ctrl.pc_write   = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_JAL: begin
        ctrl.adr_to_pc  = 1'b1;
        ctrl.pc_write   = 1'b1;
        ctrl.pc_to_reg  = 1'b1;
        ctrl.last_reg   = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_JR: begin
        ctrl.reg_to_pc  = 1'b1;
        ctrl.pc_write   = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

  // While reset is held the FSM sits in FETCH, but its strobes must stay low.
  assign ctrl_out = rst ? ctrl : '0;

  assign pc_write    = ctrl_out.pc_write;
  assign ir_write    = ctrl_out.ir_write;
  assign ALUOpration = ctrl_out.alu_op;
  assign MemRead     = ctrl_out.mem_read;
  assign MemWrite    = ctrl_out.mem_write;
  assign RegWrite    = ctrl_out.reg_write;
  assign PCSrc       = ctrl_out.pc_src;
  assign RegDst      = ctrl_out.reg_dst;
  assign ALUSrc      = ctrl_out.alu_src;
  assign MemToReg    = ctrl_out.mem_to_reg;
  assign PCToReg     = ctrl_out.pc_to_reg;
  assign LastReg     = ctrl_out.last_reg;
  assign AdrToPC     = ctrl_out.adr_to_pc;
  assign RegToPC     = ctrl_out.reg_to_pc;
  assign instr_done  = ctrl_out.instr_done;
  assign illegal     = illegal_q;
  assign mem_err     = mem_err_q;
  assign instr_count = count_q;

  // State, wait counter, retire counter and sticky error flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      count_q   <= '0;
      illegal_q <= 1'b0;
      mem_err_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q   <= state_d;
      wait_q    <= wait_d;
      count_q   <= count_q + 32'(ctrl.instr_done);
      illegal_q <= illegal_q | (state_q == S_ILL);
      mem_err_q <= mem_err_q | timeout;
    end
  end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Self-checking bench for mips_mc_ctrl: each instruction is expanded by a
// reference model into its expected per-cycle control vectors and mem_ready
// pattern; random instruction streams and directed corner cases are run.
module tb_mips_mc_ctrl;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  opc, func;
  logic        zero, mem_ready;
  logic        pc_write, ir_write;
  logic [2:0]  ALUOpration;
  logic        MemRead, MemWrite, RegWrite, PCSrc, RegDst, ALUSrc;
  logic        MemToReg, PCToReg, LastReg, AdrToPC, RegToPC;
  logic        instr_done, illegal, mem_err;
  logic [31:0] instr_count;

  mips_mc_ctrl #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .opc(opc), .func(func), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
    .ALUOpration(ALUOpration), .MemRead(MemRead), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .PCSrc(PCSrc), .RegDst(RegDst), .ALUSrc(ALUSrc),
    .MemToReg(MemToReg), .PCToReg(PCToReg), .LastReg(LastReg),
    .AdrToPC(AdrToPC), .RegToPC(RegToPC), .instr_done(instr_done),
    .illegal(illegal), .mem_err(mem_err), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // Observed control vector, one bit per output (ALU op in bits 14:12).
  logic [16:0] obs;
  assign obs = {pc_write, ir_write, ALUOpration, MemRead, MemWrite, RegWrite,
                PCSrc, RegDst, ALUSrc, MemToReg, PCToReg, LastReg, AdrToPC,
                RegToPC, instr_done};

  localparam logic [16:0] M_PCW  = 17'h10000;
  localparam logic [16:0] M_IRW  = 17'h08000;
  localparam logic [16:0] M_MR   = 17'h00800;
  localparam logic [16:0] M_MW   = 17'h00400;
  localparam logic [16:0] M_RW   = 17'h00200;
  localparam logic [16:0] M_PCS  = 17'h00100;
  localparam logic [16:0] M_RDST = 17'h00080;
  localparam logic [16:0] M_ASRC = 17'h00040;
  localparam logic [16:0] M_MTR  = 17'h00020;
  localparam logic [16:0] M_PTR  = 17'h00010;
  localparam logic [16:0] M_LR   = 17'h00008;
  localparam logic [16:0] M_ADR  = 17'h00004;
  localparam logic [16:0] M_RTP  = 17'h00002;
  localparam logic [16:0] M_DONE = 17'h00001;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model architectural state.
  logic [31:0] m_count;
  logic        m_ill, m_err;
  logic [16:0] exp_q[$];
  logic        mr_q[$];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] alu(input logic [2:0] op);
    return {2'b00, op, 12'h000};
  endfunction

  // R-type ALU table; bit 3 set means the function code is not an ALU op.
  function automatic logic [3:0] r_op(input logic [5:0] f);
    case (f)
      6'b100000: return 4'd2;
      6'b100010: return 4'd3;
      6'b100100: return 4'd0;
      6'b100101: return 4'd1;
      6'b101010: return 4'd4;
      default:   return 4'b1000;
    endcase
  endfunction

  task automatic push(input logic [16:0] v, input logic r);
    exp_q.push_back(v);
    mr_q.push_back(r);
  endtask

  // Expand one instruction into expected cycles, drive it, compare each cycle.
  // 'waits' = stalled cycles before mem_ready; waits >= TO means never ready.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f,
                           input logic z, input int waits);
    logic [16:0] base;
    logic [3:0]  rop;
    logic        retire, bad, tmo;
    retire = 1'b1; bad = 1'b0; tmo = 1'b0;
    base   = M_ASRC | alu(3'd2);
    exp_q.delete(); mr_q.delete();
    push(M_PCW | M_IRW, 1'($urandom));
    push(17'h0, 1'($urandom));
    rop = r_op(f);
    case (o)
      6'b000000: begin
        if (f == 6'b001000) begin
          push(M_RTP | M_PCW | M_DONE, 1'($urandom));
        end else if (!rop[3]) begin
          push(alu(rop[2:0]), 1'($urandom));
          push(alu(rop[2:0]) | M_RDST | M_RW | M_DONE, 1'($urandom));
        end else begin
          push(17'h0, 1'($urandom)); retire = 1'b0; bad = 1'b1;
        end
      end
      6'b001000, 6'b001010: begin
        rop = (o == 6'b001010) ? 4'd4 : 4'd2;
        push(M_ASRC | alu(rop[2:0]), 1'($urandom));
        push(M_ASRC | alu(rop[2:0]) | M_RW | M_DONE, 1'($urandom));
      end
      6'b100011: begin
        push(base, 1'($urandom));
        if (waits >= TO) begin
          for (int k = 0; k < TO; k++)
            push(base | M_MR | ((k == TO - 1) ? M_DONE : 17'h0), 1'b0);
          tmo = 1'b1;
        end else begin
          for (int k = 0; k < waits; k++) push(base | M_MR, 1'b0);
          push(base | M_MR, 1'b1);
          push(base | M_MR | M_MTR | M_RW | M_DONE, 1'($urandom));
        end
      end
      6'b101011: begin
        push(base, 1'($urandom));
        if (waits >= TO) begin
          for (int k = 0; k < TO; k++)
            push((k == TO - 1) ? (base | M_DONE) : (base | M_MW), 1'b0);
          tmo = 1'b1;
        end else begin
          for (int k = 0; k < waits; k++) push(base | M_MW, 1'b0);
          push(base | M_MW | M_DONE, 1'b1);
        end
      end
      6'b000100: push(alu(3'd3) | M_PCS | (z ? M_PCW : 17'h0) | M_DONE,
                      1'($urandom));
      6'b000010: push(M_ADR | M_PCW | M_DONE, 1'($urandom));
      6'b000011: push(M_ADR | M_PCW | M_PTR | M_LR | M_RW | M_DONE,
                      1'($urandom));
      default: begin
        push(17'h0, 1'($urandom)); retire = 1'b0; bad = 1'b1;
      end
    endcase

    opc = o; func = f; zero = z;
    for (int i = 0; i < exp_q.size(); i++) begin
      mem_ready = mr_q[i];
      @(negedge clk);
      if (i == 0) begin
        check("instr_count", instr_count, m_count);
        check("illegal", {31'd0, illegal}, {31'd0, m_ill});
        check("mem_err", {31'd0, mem_err}, {31'd0, m_err});
      end
      check($sformatf("ctrl opc=%b func=%b w=%0d cyc%0d", o, f, waits, i),
            {15'd0, obs}, {15'd0, exp_q[i]});
      @(posedge clk); #1;
    end
    if (retire) m_count = m_count + 32'd1;
    if (bad)    m_ill = 1'b1;
    if (tmo)    m_err = 1'b1;
  endtask

  task automatic run_random();
    logic [5:0] o, f;
    int sel, w;
    sel = $urandom_range(0, 11);
    f   = 6'($urandom);
    case (sel)
      0: begin o = 6'b000000; f = 6'b100000; end
      1: begin o = 6'b000000; f = 6'b100010; end
      2: begin o = 6'b000000; f = 6'b100100; end
      3: begin o = 6'b000000; f = 6'b100101; end
      4: begin o = 6'b000000; f = 6'b101010; end
      5: begin o = 6'b000000; f = 6'b001000; end
      6: o = ($urandom_range(0, 1) == 0) ? 6'b001000 : 6'b001010;
      7: o = 6'b100011;
      8: o = 6'b101011;
      9: o = 6'b000100;
      10: o = ($urandom_range(0, 1) == 0) ? 6'b000010 : 6'b000011;
      default: o = 6'($urandom);
    endcase
    case ($urandom_range(0, 9))
      6: w = TO - 1;
      7: w = TO;
      8: w = TO + 3;
      default: w = $urandom_range(0, 3);
    endcase
    run_instr(o, f, 1'($urandom), w);
  endtask

  initial begin
    rst = 1'b0; opc = '0; func = '0; zero = 1'b0; mem_ready = 1'b0;
    m_count = '0; m_ill = 1'b0; m_err = 1'b0;

    // Reset state: FETCH strobes suppressed, counters and flags clear.
    #12;
    check("reset ctrl", {15'd0, obs}, 32'd0);
    check("reset count", instr_count, 32'd0);
    check("reset flags", {30'd0, illegal, mem_err}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Directed sequences.
    run_instr(6'b000000, 6'b100000, 1'b0, 0);      // add
    run_instr(6'b100011, 6'b010101, 1'b0, 3);      // lw, 3 stalls
    run_instr(6'b000100, 6'b000000, 1'b1, 0);      // beq taken
    run_instr(6'b000100, 6'b000000, 1'b0, 0);      // beq not taken
    run_instr(6'b101011, 6'b000000, 1'b0, TO);     // sw timeout
    run_instr(6'b111111, 6'b000000, 1'b0, 0);      // illegal opcode
    run_instr(6'b000011, 6'b000000, 1'b0, 0);      // jal
    run_instr(6'b101011, 6'b000000, 1'b0, TO - 1); // ready on last allowed cycle
    run_instr(6'b100011, 6'b000000, 1'b0, TO - 1);
    run_instr(6'b100011, 6'b000000, 1'b0, TO);     // lw timeout
    run_instr(6'b101011, 6'b000000, 1'b0, 0);      // sw zero wait
    run_instr(6'b001010, 6'b000000, 1'b0, 0);      // slti
    run_instr(6'b000000, 6'b001000, 1'b0, 0);      // jr
    run_instr(6'b000000, 6'b111111, 1'b0, 0);      // bad R-type func

    for (int n = 0; n < 200; n++) run_random();

    // Reset in the middle of an lw stall.
    opc = 6'b100011; func = 6'($urandom); mem_ready = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("midwait rst ctrl", {15'd0, obs}, 32'd0);
    check("midwait rst count", instr_count, 32'd0);
    check("midwait rst flags", {30'd0, illegal, mem_err}, 32'd0);
    @(posedge clk); #1;
    check("held rst ctrl", {15'd0, obs}, 32'd0);
    rst = 1'b1;
    m_count = '0; m_ill = 1'b0; m_err = 1'b0;

    run_instr(6'b000000, 6'b100010, 1'b0, 0);      // sub, starts in FETCH
    for (int n = 0; n < 30; n++) run_random();
    @(negedge clk);
    check("final count", instr_count, m_count);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
